// File: rtl/pe_bus_arbiter.sv
// Round-robin PE bus arbiter: one-cycle request-to-grant, registered one-hot grant,
// a mandatory turnaround cycle between tenures, and a hold limit that forcibly revokes a grant.
module pe_bus_arbiter #(
  parameter int N_PE     = 4,
  parameter int MAX_HOLD = 64,
  localparam int IDW     = $clog2(N_PE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_PE-1:0] bus_request,
  output logic [N_PE-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            bus_busy,
  output logic            timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_owner;
  logic [15:0]       r_hold_cnt;
  logic [N_PE-1:0]   r_grant;
  logic              r_timeout;

  logic              w_found;
  logic [IDW-1:0]    w_win;
  logic              w_take;
  logic              w_timeout;
  logic              w_hold_max;
  logic [IDW-1:0]    w_ptr_nxt;

  // First requester at or above r_ptr, wrapping modulo N_PE.
  always_comb begin
    logic [IDW:0]   v_sum;
    logic [IDW-1:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_sum   = '0;
    v_idx   = '0;
    for (int i = 0; i < N_PE; i++) begin
      v_sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (v_sum >= (IDW+1)'(N_PE)) begin
        v_sum = v_sum - (IDW+1)'(N_PE);
      end
      v_idx = v_sum[IDW-1:0];
      if (!w_found && bus_request[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  assign w_hold_max = (r_hold_cnt == 16'(MAX_HOLD - 1));
  assign w_ptr_nxt  = (r_owner == IDW'(N_PE - 1)) ? '0 : r_owner + IDW'(1);

  // TURN already sees the advanced pointer, so it arbitrates like IDLE to keep the gap at one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE, S_TURN: begin
        if (w_found) begin
          w_state_nxt = S_OWN;
          w_take      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OWN: begin
        if (!bus_request[r_owner] || w_hold_max) begin
          w_state_nxt = S_TURN;
          w_timeout   = bus_request[r_owner] && w_hold_max;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_grant    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= w_timeout;
      if (w_take) begin
        r_owner    <= w_win;
        r_grant    <= N_PE'(1) << w_win;
        r_hold_cnt <= '0;
      end else if (r_state == S_OWN) begin
        if (w_state_nxt == S_TURN) begin
          r_grant <= '0;
          r_ptr   <= w_ptr_nxt;
        end else begin
          r_hold_cnt <= r_hold_cnt + 16'd1;
        end
      end
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_owner;
  assign bus_busy    = |r_grant;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Bench for pe_bus_arbiter (N_PE=4, MAX_HOLD=8): vector table, corner sequences, random vs model.
module tb_pe_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] bus_request;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         bus_busy;
  logic         timeout_err;

  int checks   = 0;
  int failures = 0;

  pe_bus_arbiter #(.N_PE(N), .MAX_HOLD(MH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_request (bus_request),
    .grant       (grant),
    .grant_id    (grant_id),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    logic [N-1:0] g;
    int           id;
    bit           to;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: owner index (-1 = none), tenure length, rotating priority start.
  int m_owner, m_len, m_ptr, m_id;
  bit m_to;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input bit rst, input logic [N-1:0] req,
                              input logic [N-1:0] g, input int id, input bit to);
    vec_t v;
    v.rst = rst; v.req = req; v.g = g; v.id = id; v.to = to;
    vecs.push_back(v);
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_len = 0; m_ptr = 0; m_id = 0; m_to = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_len == MH) begin
        m_to    = r[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_len++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_len   = 1;
          m_id    = m_owner;
        end
      end
    end
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    bus_request = '0;
    tick();
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(bus_busy), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] req;
    int exp_g;

    reset = 1'b0;
    bus_request = '0;

    // Reset/idle
    add(1, 4'h0, 4'h0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 4'h0, 4'h0, 0, 0);
    // Single requester PE2
    for (int i = 0; i < 5; i++) add(0, 4'h4, 4'h4, 2, 0);
    add(0, 4'h0, 4'h0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0);
    // Hold limit: PE0 held; two full tenures then a partial one
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < MH; i++) add(0, 4'h1, 4'h1, 0, 0);
      add(0, 4'h1, 4'h0, 0, 1);
    end
    add(0, 4'h1, 4'h1, 0, 0);
    add(0, 4'h1, 4'h1, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0);
    // Timeout fairness: PE0 revoked, PE1 next
    add(1, 4'h0, 4'h0, 0, 0);
    for (int i = 0; i < MH; i++) add(0, 4'h3, 4'h1, 0, 0);
    add(0, 4'h3, 4'h0, 0, 1);
    add(0, 4'h3, 4'h2, 1, 0);
    add(0, 4'h3, 4'h2, 1, 0);
    add(0, 4'h0, 4'h0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0);

    foreach (vecs[i]) begin
      bus_request = vecs[i].req;
      reset = vecs[i].rst ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].g));
      chk($sformatf("vec%0d_busy", i), int'(bus_busy), int'(|vecs[i].g));
      chk($sformatf("vec%0d_timeout", i), int'(timeout_err), int'(vecs[i].to));
      if (vecs[i].rst || vecs[i].g != 0)
        chk($sformatf("vec%0d_id", i), int'(grant_id), vecs[i].id);
      reset = 1'b1;
    end

    // Round-robin: each owner holds 3 cycles, drops, re-raises during TURN
    do_reset();
    bus_request = 4'hF;
    tick();
    chk("rr_first", int'(grant), 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      chk($sformatf("rr%0d_held", k), int'(grant), 1 << k);
      bus_request = 4'hF & ~(4'h1 << k);
      tick();
      chk($sformatf("rr%0d_turn", k), int'(grant), 0);
      bus_request = 4'hF;
      tick();
      chk($sformatf("rr%0d_next", k), int'(grant), 1 << ((k + 1) % N));
      chk($sformatf("rr%0d_id", k), int'(grant_id), (k + 1) % N);
    end
    bus_request = '0;
    tick();
    tick();

    // Reset mid-tenure: grant must drop without a clock edge
    do_reset();
    bus_request = 4'h8;
    tick();
    chk("mid_grant3", int'(grant), 8);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_async_grant", int'(grant), 0);
    chk("mid_async_busy", int'(bus_busy), 0);
    chk("mid_async_to", int'(timeout_err), 0);
    tick();
    @(negedge clk);
    bus_request = 4'hF;
    reset = 1'b1;
    tick();
    chk("mid_regrant", int'(grant), 1);
    chk("mid_regrant_id", int'(grant_id), 0);

    // Randomized levels against the model
    do_reset();
    model_reset();
    req = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      end
      bus_request = req;
      tick();
      model_step(req);
      exp_g = (m_owner >= 0) ? (1 << m_owner) : 0;
      chk("rnd_grant", int'(grant), exp_g);
      chk("rnd_busy", int'(bus_busy), int'(m_owner >= 0));
      chk("rnd_timeout", int'(timeout_err), int'(m_to));
      if (m_owner >= 0) chk("rnd_id", int'(grant_id), m_id);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
